// File: rtl/row_slider_if.sv
// row_slider_if: player/controller-facing signal bundle of the sliding-row block.
//   speed       : level speed from the level/speed controller (0 behaves as 1)
//   drop        : one-cycle drop request from the debounced player button
//   go          : one-cycle pulse, judgment complete
//   next_signal : result of the last judgment (1 = success), held until the next one
//   fail        : one-cycle pulse on a miss, coincident with go
//   x_pos       : left cell of the moving row
//   width       : width of the moving row
//   row         : index of the moving row, 0 = bottom
// master = controller/renderer side, slave = row_slider.
interface row_slider_if;
    logic [3:0] speed;
    logic       drop;
    logic       go;
    logic       next_signal;
    logic       fail;
    logic [4:0] x_pos;
    logic [4:0] width;
    logic [4:0] row;

    modport master (
        output speed, drop,
        input  go, next_signal, fail, x_pos, width, row
    );

    modport slave (
        input  speed, drop,
        output go, next_signal, fail, x_pos, width, row
    );
endinterface

// File: rtl/row_slider.sv
// row_slider: slides the current stacker row left/right at a speed-dependent
// rate and, on each player drop, judges its overlap with the previously placed
// row, issuing the go/next_signal pair to the level controller.
//
// Ports:
//   clk    : system clock
//   resetn : synchronous active-low reset
//   bus    : row_slider_if.slave (speed, drop in; go, next_signal, fail,
//            x_pos, width, row out)
//
// Optional build macro: ROW_SLIDER_PERFECT_EN
//   defined   - an exact alignment above row 0 grows the row by one cell
//               (capped at COLS), pulled left if it would overhang the field
//   undefined - exact alignment is an ordinary success keeping its width
//
// state  | meaning
// -------+----------------------------------------------------------
// SLIDE  | row moves one cell per divider tick; drops are accepted
// JUDGE  | overlap of the captured row with the placed row computed
// ISSUE  | go/next_signal/fail issued, row state updated
module row_slider #(
    parameter int unsigned COLS     = 16,
    parameter int unsigned START_W  = 4,
    parameter int unsigned ROWS     = 15,
    parameter int unsigned BASE_DIV = 500000
) (
    input  logic        clk,
    input  logic        resetn,
    row_slider_if.slave bus
);
    localparam logic [4:0]  COLS_W5  = 5'(COLS);
    localparam logic [5:0]  COLS_W6  = 6'(COLS);
    localparam logic [4:0]  START_W5 = 5'(START_W);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [31:0] BASE_W32 = 32'(BASE_DIV);

    typedef enum logic [1:0] {SLIDE, JUDGE, ISSUE} state_t;

    state_t      state;
    logic [31:0] div_rem;
    logic [4:0]  x_pos_q, width_q, row_q;
    logic [4:0]  x_hold, w_hold;
    logic [4:0]  px, pw;
    logic [4:0]  ov_x_q, ov_w_q;
    logic        ok_q;
    logic        dir_left;
    logic        go_q, next_q, fail_q;

    // Rate divider: a down-counter whose value 0 marks the start of a period.
    // The period length is taken from speed only at that point, so a speed
    // change lands on the next period boundary.
    logic [3:0]  spd_eff;
    logic [31:0] period_new;
    logic [31:0] div_cur;
    logic        tick;

    assign spd_eff    = (bus.speed == 4'd0) ? 4'd1 : bus.speed;
    assign period_new = BASE_W32 * (32'd16 - {28'd0, spd_eff});
    assign div_cur    = (div_rem == 32'd0) ? period_new : div_rem;
    assign tick       = (div_cur == 32'd1);

    // Next position of the sliding row (bounce at both walls).
    logic [5:0] right_edge;
    logic [4:0] x_next;
    logic       dir_next;

    assign right_edge = {1'b0, x_pos_q} + {1'b0, width_q};

    always_comb begin
        x_next   = x_pos_q;
        dir_next = dir_left;
        if (width_q != COLS_W5) begin
            if (!dir_left) begin
                if (right_edge == COLS_W6) begin
                    dir_next = 1'b1;
                    x_next   = x_pos_q - 5'd1;
                end else begin
                    x_next = x_pos_q + 5'd1;
                end
            end else begin
                if (x_pos_q == 5'd0) begin
                    dir_next = 1'b0;
                    x_next   = x_pos_q + 5'd1;
                end else begin
                    x_next = x_pos_q - 5'd1;
                end
            end
        end
    end

    // Overlap of the captured row [x, x+w) with the placed row [px, px+pw).
    logic [5:0] a_lo, a_hi, b_lo, b_hi, lo, hi;
    logic [4:0] j_ovx, j_ovw;
`ifdef ROW_SLIDER_PERFECT_EN
    logic [5:0] grown_w;
`endif

    always_comb begin
        a_lo  = {1'b0, x_hold};
        a_hi  = a_lo + {1'b0, w_hold};
        b_lo  = {1'b0, px};
        b_hi  = b_lo + {1'b0, pw};
        lo    = (a_lo > b_lo) ? a_lo : b_lo;
        hi    = (a_hi < b_hi) ? a_hi : b_hi;
        j_ovx = lo[4:0];
        j_ovw = (hi > lo) ? 5'(hi - lo) : 5'd0;
`ifdef ROW_SLIDER_PERFECT_EN
        grown_w = ({1'b0, pw} + 6'd1 > COLS_W6) ? COLS_W6 : {1'b0, pw} + 6'd1;
`endif
        if (row_q == 5'd0) begin
            // Bottom row sits on the floor: always a full success.
            j_ovx = x_hold;
            j_ovw = w_hold;
        end
`ifdef ROW_SLIDER_PERFECT_EN
        else if (x_hold == px && w_hold == pw) begin
            j_ovw = grown_w[4:0];
            j_ovx = (b_lo + grown_w > COLS_W6) ? 5'(COLS_W6 - grown_w) : px;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= SLIDE;
            div_rem  <= 32'd0;
            x_pos_q  <= 5'd0;
            width_q  <= START_W5;
            row_q    <= 5'd0;
            x_hold   <= 5'd0;
            w_hold   <= 5'd0;
            px       <= 5'd0;
            pw       <= COLS_W5;
            ov_x_q   <= 5'd0;
            ov_w_q   <= 5'd0;
            ok_q     <= 1'b0;
            dir_left <= 1'b0;
            go_q     <= 1'b0;
            next_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            go_q   <= 1'b0;
            fail_q <= 1'b0;
            unique case (state)
                SLIDE: begin
                    if (bus.drop) begin
                        // Drop wins over a coincident tick: the pre-tick
                        // position is what gets judged.
                        x_hold <= x_pos_q;
                        w_hold <= width_q;
                        state  <= JUDGE;
                    end else begin
                        div_rem <= tick ? 32'd0 : div_cur - 32'd1;
                        if (tick) begin
                            x_pos_q  <= x_next;
                            dir_left <= dir_next;
                        end
                    end
                end
                JUDGE: begin
                    ov_x_q <= j_ovx;
                    ov_w_q <= j_ovw;
                    ok_q   <= (j_ovw != 5'd0);
                    state  <= ISSUE;
                end
                ISSUE: begin
                    go_q     <= 1'b1;
                    next_q   <= ok_q;
                    x_pos_q  <= 5'd0;
                    dir_left <= 1'b0;
                    div_rem  <= 32'd0;
                    if (ok_q) begin
                        px <= ov_x_q;
                        pw <= ov_w_q;
                        if (row_q == LAST_ROW) begin
                            row_q   <= 5'd0;
                            width_q <= START_W5;
                        end else begin
                            row_q   <= row_q + 5'd1;
                            width_q <= ov_w_q;
                        end
                    end else begin
                        fail_q  <= 1'b1;
                        row_q   <= 5'd0;
                        width_q <= START_W5;
                    end
                    state <= SLIDE;
                end
                default: state <= SLIDE;
            endcase
        end
    end

    assign bus.go          = go_q;
    assign bus.next_signal = next_q;
    assign bus.fail        = fail_q;
    assign bus.x_pos       = x_pos_q;
    assign bus.width       = width_q;
    assign bus.row         = row_q;
endmodule
